// File: rtl/hctrl_pkg.sv
// Purpose: shared select constants, in-flight slot record and match helpers for the hazard controller.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package hctrl_pkg;

  localparam int HCTRL_ADDR_W = 5;

  // EXE operand select encodings: where the operand is taken from
  localparam logic [1:0] FWD_REGF  = 2'd0;  // register file read in DEC
  localparam logic [1:0] FWD_MEM   = 2'd1;  // producer now in EXE, result at mem_exe
  localparam logic [1:0] FWD_WB    = 2'd2;  // producer now in MEM, result at wb_exe
  localparam logic [1:0] FWD_WBDEC = 2'd3;  // producer now in WB, result at wb_dec

  // One in-flight instruction as seen by the hazard logic
  typedef struct packed {
    logic                    valid;
    logic                    wr_en;
    logic                    is_load;
    logic [HCTRL_ADDR_W-1:0] dest;
  } slot_t;

  // A slot feeds a source only if it really writes a nonzero register the source reads
  function automatic logic slot_hit(input slot_t s, input logic [HCTRL_ADDR_W-1:0] rs,
                                    input logic used);
    return s.valid && s.wr_en && (s.dest != '0) && (s.dest == rs) && used;
  endfunction

  // Nearest producer wins
  function automatic logic [1:0] pick_sel(input logic hit_e, input logic hit_m,
                                          input logic hit_w);
    if (hit_e)      return FWD_MEM;
    else if (hit_m) return FWD_WB;
    else if (hit_w) return FWD_WBDEC;
    return FWD_REGF;
  endfunction

endpackage

// File: rtl/hctrl_inflight_tracker.sv
// Purpose: 3-slot shift register (E/M/W) of instructions in EXE/MEM/WB, bubble inserted when DEC does not advance.
// Latency: decode slot lands in E one clk after presentation; moves one stage per clk.
// Backpressure: none; the caller gates in_vld with its stall and the slots always shift.
module hctrl_inflight_tracker
  import hctrl_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  in_vld,
  input  slot_t dec_slot,
  output slot_t e_slot,
  output slot_t m_slot,
  output slot_t w_slot
);

  slot_t e_q, e_d;
  slot_t m_q, m_d;
  slot_t w_q, w_d;

  // Next-state: older slots advance, a non-advancing DEC becomes an invalid slot
  always_comb begin
    e_d = '0;
    if (in_vld) e_d = dec_slot;
    m_d = e_q;
    w_d = m_q;
  end

  // Slot registers, cleared to invalid by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  assign e_slot = e_q;
  assign m_slot = m_q;
  assign w_slot = w_q;

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Purpose: EXE operand forwarding selects and load-use stall/bubble control; optional perf counters with HCTRL_PERF_CNT_EN.
// Latency: selects registered 1 clk after decode presentation; stall/bubble combinational in the same cycle.
// Backpressure: emits hctrl_stall to hold PC and IF/DEC; accepts none itself.
module hazard_fwd_ctrl
  import hctrl_pkg::*;
#(
  parameter int REG_ADDR_W        = HCTRL_ADDR_W,  // must equal HCTRL_ADDR_W
  parameter int LOAD_STALL_CYCLES = 1              // legal range 1..2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dec_hctrl_valid,
  input  logic [REG_ADDR_W-1:0] dec_hctrl_rs1_add,
  input  logic [REG_ADDR_W-1:0] dec_hctrl_rs2_add,
  input  logic                  dec_hctrl_rs1_used,
  input  logic                  dec_hctrl_rs2_used,
  input  logic [REG_ADDR_W-1:0] dec_hctrl_reg_wr_add,
  input  logic                  dec_hctrl_reg_wr_en,
  input  logic                  dec_hctrl_is_load,
  output logic [1:0]            mux1_hctr,
  output logic [1:0]            mux2_hctr,
  output logic                  hctrl_stall,
`ifdef HCTRL_PERF_CNT_EN
  output logic [31:0]           hctrl_stall_cnt,
  output logic [31:0]           hctrl_fwd_cnt,
`endif
  output logic                  hctrl_bubble
);

  slot_t e_slot, m_slot, w_slot;
  slot_t dec_slot;
  logic  stall_c;

  logic hit1_e, hit1_m, hit1_w;
  logic hit2_e, hit2_m, hit2_w;
  logic load_hit_e, load_hit_m;

  logic [1:0] mux1_q, mux1_d;
  logic [1:0] mux2_q, mux2_d;

  // W-slot load flag is carried for uniformity; nothing downstream of WB needs it
  logic unused_w_is_load;
  assign unused_w_is_load = w_slot.is_load;

  // Pack the decode instruction into a tracker record
  always_comb begin
    dec_slot         = '0;
    dec_slot.valid   = dec_hctrl_valid;
    dec_slot.wr_en   = dec_hctrl_reg_wr_en;
    dec_slot.is_load = dec_hctrl_is_load;
    dec_slot.dest    = dec_hctrl_reg_wr_add;
  end

  hctrl_inflight_tracker u_tracker (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (dec_hctrl_valid & ~stall_c),
    .dec_slot (dec_slot),
    .e_slot   (e_slot),
    .m_slot   (m_slot),
    .w_slot   (w_slot)
  );

  // Source/slot matching, load-use stall and next operand selects
  always_comb begin
    hit1_e = slot_hit(e_slot, dec_hctrl_rs1_add, dec_hctrl_rs1_used);
    hit1_m = slot_hit(m_slot, dec_hctrl_rs1_add, dec_hctrl_rs1_used);
    hit1_w = slot_hit(w_slot, dec_hctrl_rs1_add, dec_hctrl_rs1_used);
    hit2_e = slot_hit(e_slot, dec_hctrl_rs2_add, dec_hctrl_rs2_used);
    hit2_m = slot_hit(m_slot, dec_hctrl_rs2_add, dec_hctrl_rs2_used);
    hit2_w = slot_hit(w_slot, dec_hctrl_rs2_add, dec_hctrl_rs2_used);

    // A load result is not ready until it leaves MEM (penalty 1) or WB entry (penalty 2)
    load_hit_e = (hit1_e | hit2_e) & e_slot.is_load;
    load_hit_m = (hit1_m | hit2_m) & m_slot.is_load & (LOAD_STALL_CYCLES >= 2);
    stall_c    = dec_hctrl_valid & (load_hit_e | load_hit_m);

    // Stalled or empty decode slot puts a bubble in EXE, which reads the register file
    mux1_d = FWD_REGF;
    mux2_d = FWD_REGF;
    if (dec_hctrl_valid && !stall_c) begin
      mux1_d = pick_sel(hit1_e, hit1_m, hit1_w);
      mux2_d = pick_sel(hit2_e, hit2_m, hit2_w);
    end
  end

  // Select registers, valid while the consumer sits in EXE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mux1_q <= FWD_REGF;
      mux2_q <= FWD_REGF;
    end else begin
      mux1_q <= mux1_d;
      mux2_q <= mux2_d;
    end
  end

  assign mux1_hctr    = mux1_q;
  assign mux2_hctr    = mux2_q;
  assign hctrl_stall  = stall_c;
  assign hctrl_bubble = stall_c;

`ifdef HCTRL_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] fwd_cnt_q, fwd_cnt_d;

  // Count stall cycles and cycles where EXE takes any forwarded operand; both wrap
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (stall_c) stall_cnt_d = stall_cnt_q + 32'd1;
    if ((mux1_q != FWD_REGF) || (mux2_q != FWD_REGF)) fwd_cnt_d = fwd_cnt_q + 32'd1;
  end

  // Counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign hctrl_stall_cnt = stall_cnt_q;
  assign hctrl_fwd_cnt   = fwd_cnt_q;
`endif

endmodule
